// File: rtl/decode_queue_ctrl.sv
// Flow controller and flush sequencer for decode_queue: occupancy tracking, fetch admission, flush/hold.
// Optional statistics counters are compiled in when DQCTRL_STATS_EN is defined.
module decode_queue_ctrl #(
  parameter  int DQ_N         = 8,
  parameter  int MQ_N         = 4,
  parameter  int REDIRECT_LAT = 2,
  localparam int OCC_W        = $clog2(DQ_N + 1),
  localparam int CNT_W        = $clog2(MQ_N + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fet_req,
  input  logic [CNT_W-1:0] fet_cnt,
  output logic             fet_valid,
  output logic             fet_ready,
  input  logic             dec_ready,
  input  logic             redirect,
  output logic             dq_stall,
  output logic             dq_flush,
  output logic [OCC_W-1:0] occ,
  output logic             dq_empty,
  output logic             dq_full
`ifdef DQCTRL_STATS_EN
  ,
  output logic [31:0]      stat_full_cyc,
  output logic [15:0]      stat_flush,
  output logic [31:0]      stat_empty_cyc
`endif
);

  localparam int SUM_W = OCC_W + 1;

  typedef enum logic [1:0] {
    ST_RST_FLUSH,
    ST_RUN,
    ST_FLUSH,
    ST_HOLD
  } state_t;

  state_t           state, state_next;
  logic [OCC_W-1:0] occ_next;
  logic [3:0]       hold_cnt, hold_next;
  logic             pop;
  logic             fits;
  logic [SUM_W-1:0] room;

  // Occupancy after this cycle's pop plus the offered packet, one bit wider so it never wraps.
  assign pop  = (state == ST_RUN) && dec_ready && (occ != '0);
  assign room = {1'b0, occ} - SUM_W'(pop) + SUM_W'(fet_cnt);
  assign fits = (room <= SUM_W'(DQ_N));

  assign fet_ready = (state == ST_RUN);
  assign dq_flush  = (state == ST_RST_FLUSH) || (state == ST_FLUSH);
  assign dq_empty  = (occ == '0);
  assign dq_full   = (occ == OCC_W'(DQ_N));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    occ_next   = occ;
    hold_next  = hold_cnt;
    fet_valid  = 1'b0;
    dq_stall   = 1'b0;
    case (state)
      ST_RST_FLUSH: state_next = ST_RUN;  // a redirect here is absorbed
      ST_RUN: begin
        dq_stall = ~dec_ready;
        if (redirect) begin
          state_next = ST_FLUSH;
          occ_next   = '0;
        end else begin
          fet_valid = fet_req && dec_ready && (fet_cnt != '0) && fits;
          occ_next  = OCC_W'({1'b0, occ} - SUM_W'(pop)
                             + (fet_valid ? SUM_W'(fet_cnt) : SUM_W'(0)));
        end
      end
      ST_FLUSH: begin
        occ_next = '0;
        if (!redirect) begin
          state_next = ST_HOLD;
          hold_next  = 4'(REDIRECT_LAT - 1);
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_next = ST_FLUSH;
          occ_next   = '0;
        end else if (hold_cnt == '0) begin
          state_next = ST_RUN;
        end else begin
          hold_next = hold_cnt - 4'd1;
        end
      end
      default: state_next = ST_RST_FLUSH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_RST_FLUSH;
      occ      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      occ      <= occ_next;
      hold_cnt <= hold_next;
    end
  end

`ifdef DQCTRL_STATS_EN
  logic refused;
  logic empty_cyc;
  logic flush_entry;

  assign refused     = (state == ST_RUN) && !redirect && fet_req && (fet_cnt != '0) && !fits;
  assign empty_cyc   = (state == ST_RUN) && dec_ready && (occ == '0);
  assign flush_entry = (state_next == ST_FLUSH);

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_full_cyc  <= '0;
      stat_flush     <= '0;
      stat_empty_cyc <= '0;
    end else begin
      if (refused && (stat_full_cyc != '1))
        stat_full_cyc <= stat_full_cyc + 32'd1;
      if (flush_entry && (stat_flush != '1))
        stat_flush <= stat_flush + 16'd1;
      if (empty_cyc && (stat_empty_cyc != '1))
        stat_empty_cyc <= stat_empty_cyc + 32'd1;
    end
  end
`endif

  a_occ_bound: assert property (@(posedge clk) disable iff (!rstn)
    occ <= OCC_W'(DQ_N));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rstn)
    fet_req |-> (fet_cnt <= CNT_W'(MQ_N)));

endmodule
